// File: rtl/mc_mainfsm.sv
// mc_mainfsm: main control FSM for the multicycle MIPS datapath.
//
// Moves each instruction through fetch, decode, execute, memory and
// writeback. It drives the datapath mux selects and write enables, and
// passes aluop on to the ALU decoder. Instruction fetch, load read and
// store write each wait for the memory-ready handshake.
//
// Memory handshake: the FSM presents an access (iord, and memwrite for a
// store) for as long as it sits in FETCH, MEMRD or MEMWR. The access
// completes on a rising edge where memready=1, and the FSM leaves that state
// on the same edge. In every other state memready is ignored.
//
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous, active-high; forces state to FETCH
//   op        opcode from the instruction register, sampled in DECODE/MEMADR
//   memready  memory completes the current access this cycle
//   iord      memory address select (0=PC, 1=ALUOut)
//   irwrite   instruction register load enable
//   pcwrite   unconditional PC load enable
//   branch    conditional PC load enable (ANDed with zero in the datapath)
//   pcsrc     next-PC select (00=ALU, 01=ALUOut, 10=jump target)
//   alusrca   ALU A select (0=PC, 1=rs)
//   alusrcb   ALU B select (00=rt, 01=4, 10=signimm, 11=signimm<<2)
//   aluop     to aludec (00=add, 01=sub, 10=use funct)
//   memwrite  data memory write strobe
//   regwrite  register file write enable
//   regdst    write register select (0=rt, 1=rd)
//   memtoreg  writeback select (0=ALUOut, 1=memory data)
//   illegal   one-cycle pulse when DECODE sees an unsupported opcode
//   state     current state encoding (debug)
module mc_mainfsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       memready,
  output logic       iord,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       branch,
  output logic [1:0] pcsrc,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic       memwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
  } state_t;

  state_t cur_state, nxt_state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cur_state <= FETCH;
    else       cur_state <= nxt_state;
  end

  assign state = cur_state;

  always_comb begin
    nxt_state = FETCH;
    iord      = 1'b0;
    irwrite   = 1'b0;
    pcwrite   = 1'b0;
    branch    = 1'b0;
    pcsrc     = 2'b00;
    alusrca   = 1'b0;
    alusrcb   = 2'b00;
    aluop     = 2'b00;
    memwrite  = 1'b0;
    regwrite  = 1'b0;
    regdst    = 1'b0;
    memtoreg  = 1'b0;
    illegal   = 1'b0;

    case (cur_state)
      FETCH: begin
        // PC+4 is computed every fetch cycle; IR and PC load only on the
        // cycle the memory actually returns the instruction.
        alusrcb   = 2'b01;
        irwrite   = memready;
        pcwrite   = memready;
        nxt_state = memready ? DECODE : FETCH;
      end
      DECODE: begin
        // Branch target PC + (signimm<<2) is precomputed into ALUOut.
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: nxt_state = MEMADR;
          OP_RTYPE:     nxt_state = RTYPEEX;
          OP_BEQ:       nxt_state = BEQEX;
          OP_ADDI:      nxt_state = ADDIEX;
          OP_J:         nxt_state = JEX;
          default: begin
            nxt_state = FETCH;
            illegal   = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        if (op == OP_LW)      nxt_state = MEMRD;
        else if (op == OP_SW) nxt_state = MEMWR;
        else                  nxt_state = FETCH;
      end
      MEMRD: begin
        iord      = 1'b1;
        nxt_state = memready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      MEMWR: begin
        // Write strobe held for the whole access, until memready completes it.
        iord      = 1'b1;
        memwrite  = 1'b1;
        nxt_state = memready ? FETCH : MEMWR;
      end
      RTYPEEX: begin
        alusrca   = 1'b1;
        aluop     = 2'b10;
        nxt_state = RTYPEWB;
      end
      RTYPEWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      BEQEX: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      ADDIEX: begin
        alusrca   = 1'b1;
        alusrcb   = 2'b10;
        nxt_state = ADDIWB;
      end
      ADDIWB: begin
        regwrite = 1'b1;
      end
      JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: begin
        // Unreachable encodings 12-15: all outputs zero, recover to FETCH.
        nxt_state = FETCH;
      end
    endcase

    // The state register is already FETCH during reset, so the mux selects
    // show their FETCH values; the strobes are killed combinationally so
    // nothing writes while reset is held.
    if (reset) begin
      irwrite  = 1'b0;
      pcwrite  = 1'b0;
      branch   = 1'b0;
      memwrite = 1'b0;
      regwrite = 1'b0;
      illegal  = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_mainfsm.sv
// Testbench for mc_mainfsm: a table of per-cycle {inputs, expected state,
// expected control word} records, plus a hand-written reset-mid-instruction
// sequence.
//
// Control word bit order (16 bits, MSB first):
//   iord irwrite pcwrite branch pcsrc[1:0] alusrca alusrcb[1:0] aluop[1:0]
//   memwrite regwrite regdst memtoreg illegal
module tb_mc_mainfsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       memready;
  logic       iord, irwrite, pcwrite, branch, alusrca, memwrite;
  logic       regwrite, regdst, memtoreg, illegal;
  logic [1:0] pcsrc, alusrcb, aluop;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  mc_mainfsm dut (
    .clk(clk), .reset(reset), .op(op), .memready(memready),
    .iord(iord), .irwrite(irwrite), .pcwrite(pcwrite), .branch(branch),
    .pcsrc(pcsrc), .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop),
    .memwrite(memwrite), .regwrite(regwrite), .regdst(regdst),
    .memtoreg(memtoreg), .illegal(illegal), .state(state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Hand-computed control words.
  localparam logic [15:0] C_FETCH_RDY  = 16'h6080;
  localparam logic [15:0] C_FETCH_WAIT = 16'h0080;
  localparam logic [15:0] C_DECODE     = 16'h0180;
  localparam logic [15:0] C_DECODE_ILL = 16'h0181;
  localparam logic [15:0] C_MEMADR     = 16'h0300;
  localparam logic [15:0] C_MEMRD      = 16'h8000;
  localparam logic [15:0] C_MEMWB      = 16'h000A;
  localparam logic [15:0] C_MEMWR      = 16'h8010;
  localparam logic [15:0] C_RTYPEEX    = 16'h0240;
  localparam logic [15:0] C_RTYPEWB    = 16'h000C;
  localparam logic [15:0] C_BEQEX      = 16'h1620;
  localparam logic [15:0] C_ADDIEX     = 16'h0300;
  localparam logic [15:0] C_ADDIWB     = 16'h0008;
  localparam logic [15:0] C_JEX        = 16'h2800;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        mr;
    logic [3:0]  exp_state;
    logic [15:0] exp_ctl;
    string       name;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [15:0] ctl_word();
    return {iord, irwrite, pcwrite, branch, pcsrc, alusrca, alusrcb, aluop,
            memwrite, regwrite, regdst, memtoreg, illegal};
  endfunction

  task automatic add(input logic rst, input logic [5:0] o, input logic mr,
                     input logic [3:0] st, input logic [15:0] ctl,
                     input string name);
    vec_t v;
    v.rst = rst; v.op = o; v.mr = mr;
    v.exp_state = st; v.exp_ctl = ctl; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [3:0] exp_st,
                       input logic [15:0] exp_ctl);
    logic [15:0] got;
    got = ctl_word();
    checks++;
    if (state !== exp_st) begin
      errors++;
      $display("FAIL %s state: got %0d expected %0d", name, state, exp_st);
    end
    checks++;
    if (got !== exp_ctl) begin
      errors++;
      $display("FAIL %s ctl: got %h expected %h", name, got, exp_ctl);
    end
  endtask

  // driver: inputs change at negedge, outputs are checked 1ns later, the
  // state advances on the following posedge.
  task automatic drive(input vec_t v);
    @(negedge clk);
    reset    = v.rst;
    op       = v.op;
    memready = v.mr;
    #1;
    check(v.name, v.exp_state, v.exp_ctl);
  endtask

  initial begin
    reset = 1'b1; op = 6'h00; memready = 1'b1;

    // reset holds state 0 and blocks strobes even with memready=1
    add(1, 6'h00, 1, 0, C_FETCH_WAIT, "reset_hold");
    add(0, 6'h00, 1, 0, C_FETCH_RDY,  "post_reset_fetch");
    // LW, memready high: 0,1,2,3,4,0
    add(0, 6'h23, 1, 1, C_DECODE,     "lw_decode");
    add(0, 6'h23, 1, 2, C_MEMADR,     "lw_memadr");
    add(0, 6'h23, 1, 3, C_MEMRD,      "lw_memrd");
    add(0, 6'h23, 1, 4, C_MEMWB,      "lw_memwb");
    // SW, memready ignored in MEMADR, 2 wait cycles in MEMWR
    add(0, 6'h2B, 1, 0, C_FETCH_RDY,  "sw_fetch");
    add(0, 6'h2B, 1, 1, C_DECODE,     "sw_decode");
    add(0, 6'h2B, 0, 2, C_MEMADR,     "sw_memadr");
    add(0, 6'h2B, 0, 5, C_MEMWR,      "sw_memwr_w1");
    add(0, 6'h2B, 0, 5, C_MEMWR,      "sw_memwr_w2");
    add(0, 6'h2B, 1, 5, C_MEMWR,      "sw_memwr_done");
    // RTYPE, memready ignored in execute/writeback
    add(0, 6'h00, 1, 0, C_FETCH_RDY,  "rt_fetch");
    add(0, 6'h00, 1, 1, C_DECODE,     "rt_decode");
    add(0, 6'h00, 0, 6, C_RTYPEEX,    "rt_ex");
    add(0, 6'h00, 0, 7, C_RTYPEWB,    "rt_wb");
    // BEQ
    add(0, 6'h04, 1, 0, C_FETCH_RDY,  "beq_fetch");
    add(0, 6'h04, 1, 1, C_DECODE,     "beq_decode");
    add(0, 6'h04, 1, 8, C_BEQEX,      "beq_ex");
    // fetch stall 3 cycles, then J
    add(0, 6'h02, 0, 0, C_FETCH_WAIT, "j_stall1");
    add(0, 6'h02, 0, 0, C_FETCH_WAIT, "j_stall2");
    add(0, 6'h02, 0, 0, C_FETCH_WAIT, "j_stall3");
    add(0, 6'h02, 1, 0, C_FETCH_RDY,  "j_fetch");
    add(0, 6'h02, 1, 1, C_DECODE,     "j_decode");
    add(0, 6'h02, 1, 11, C_JEX,       "j_ex");
    // ADDI
    add(0, 6'h08, 1, 0, C_FETCH_RDY,  "addi_fetch");
    add(0, 6'h08, 1, 1, C_DECODE,     "addi_decode");
    add(0, 6'h08, 1, 9, C_ADDIEX,     "addi_ex");
    add(0, 6'h08, 1, 10, C_ADDIWB,    "addi_wb");
    // LW with one read wait cycle
    add(0, 6'h23, 1, 0, C_FETCH_RDY,  "lw2_fetch");
    add(0, 6'h23, 1, 1, C_DECODE,     "lw2_decode");
    add(0, 6'h23, 1, 2, C_MEMADR,     "lw2_memadr");
    add(0, 6'h23, 0, 3, C_MEMRD,      "lw2_memrd_wait");
    add(0, 6'h23, 1, 3, C_MEMRD,      "lw2_memrd_done");
    add(0, 6'h23, 0, 4, C_MEMWB,      "lw2_memwb");
    // illegal opcode: one-cycle pulse, back to FETCH
    add(0, 6'h3F, 1, 0, C_FETCH_RDY,  "ill_fetch");
    add(0, 6'h3F, 1, 1, C_DECODE_ILL, "ill_decode");
    add(0, 6'h3F, 0, 0, C_FETCH_WAIT, "ill_after");
    // RTYPE up to RTYPEEX for the reset sequence below
    add(0, 6'h00, 1, 0, C_FETCH_RDY,  "rst_seq_fetch");
    add(0, 6'h00, 1, 1, C_DECODE,     "rst_seq_decode");
    add(0, 6'h00, 1, 6, C_RTYPEEX,    "rst_seq_ex");

    for (int i = 0; i < vecs.size(); i++) drive(vecs[i]);

    // Reset asserted in the middle of RTYPEEX: state drops to FETCH at once
    // and strobes stay low even though memready=1.
    #1;
    reset = 1'b1;
    #1;
    check("rst_mid_async", 4'd0, C_FETCH_WAIT);
    @(posedge clk);
    #1;
    check("rst_mid_held", 4'd0, C_FETCH_WAIT);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_release_fetch", 4'd0, C_FETCH_RDY);
    @(negedge clk);
    #1;
    check("rst_release_decode", 4'd1, C_DECODE);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
